uart_rx: RTL

//  Asynchronous serial receiver (8N1) for the inverter control link. Samples the

---
 rtl/uart_rx.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 asynchronous serial receiver: synchronises rxd, frames each byte and
// presents it on data_out with a fixed-width data_ok strobe.
module uart_rx #(
    parameter int CLKS_PER_BIT = 1250,
    parameter int CNT_W        = 11,
    parameter int OK_WIDTH     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data_out,
    output logic       data_ok,
    output logic       frame_err,
    output logic       busy,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    localparam int OK_CW = $clog2(OK_WIDTH + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [OK_CW-1:0] OK_LOAD   = OK_CW'(OK_WIDTH);

    state_t           state, state_next;
    logic             rxd_m, rxd_s, rxd_d;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic [OK_CW-1:0] ok_cnt;

    logic fall_edge;
    logic start_tick;
    logic bit_tick;
    logic stop_good;
    logic stop_bad;

    // Two-flop synchroniser plus one delay flop for edge detection; all idle high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
            rxd_d <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
            rxd_d <= rxd_s;
        end
    end

    assign fall_edge  = rxd_d & ~rxd_s;
    assign start_tick = (state == START) && (cnt == HALF_LAST);
    assign bit_tick   = (cnt == BIT_LAST);
    assign stop_good  = (state == STOP) && bit_tick && rxd_s;
    assign stop_bad   = (state == STOP) && bit_tick && !rxd_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (fall_edge) begin
                    state_next = START;
                end
            end
            START: begin
                if (start_tick) begin
                    state_next = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_tick && (bit_idx == 3'd7)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    state_next = rxd_s ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (rxd_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        state_dbg = state;
    end

    // Bit timer restarts on every state change and after each data sample; it
    // saturates at its terminal value rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if ((state != state_next) || ((state == DATA) && bit_tick)) begin
            cnt <= '0;
        end else if (((state == START) || (state == DATA) || (state == STOP)) &&
                     (cnt != BIT_LAST)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
        end else if (state == START) begin
            bit_idx <= 3'd0;
        end else if ((state == DATA) && bit_tick) begin
            bit_idx <= bit_idx + 3'd1;
            shreg   <= {rxd_s, shreg[7:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out  <= 8'h00;
            frame_err <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            if (stop_good) begin
                data_out <= shreg;
            end
        end
    end

    // Strobe timer runs independently of the FSM so a new frame cannot cut it short.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ok_cnt <= '0;
        end else if (stop_good) begin
            ok_cnt <= OK_LOAD;
        end else if (ok_cnt != '0) begin
            ok_cnt <= ok_cnt - OK_CW'(1);
        end
    end

    assign data_ok = (ok_cnt != '0);

endmodule
